noc_input_route_buffer: RTL and testbench

// - Router-side input stage, one instance per direction. Consumes one to_router[i] flit stream coming from the position mux.
// - Buffers flits in a DEPTH-entry FIFO and computes the XY route from each head flit.
// - Holds that route for every flit of the packet and presents flit plus one-hot output port to the switch allocator.

---
 rtl/noc_input_route_buffer_pkg.sv | 48 ++++
 rtl/noc_sync_fifo.sv | 60 ++++++
 rtl/noc_input_route_buffer.sv | 110 +++++++++++
 tb/tb_noc_input_route_buffer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_input_route_buffer_pkg.sv
// Shared types, widths and the XY route helper for the router input stage.
package noc_input_route_buffer_pkg;

  localparam int unsigned FLIT_WIDTH  = 32;
  localparam int unsigned COORD_W     = 4;
  // Route helper takes coordinates at this width so wider meshes still fit.
  localparam int unsigned COORD_MAX_W = 16;
  localparam int unsigned ROUTE_W     = 5;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  // Bit index of each output port inside the one-hot route vector.
  typedef enum logic [2:0] {
    PORT_EAST  = 3'd0,
    PORT_WEST  = 3'd1,
    PORT_SOUTH = 3'd2,
    PORT_NORTH = 3'd3,
    PORT_LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } route_state_e;

  // Dimension-ordered XY routing: resolve X first, then Y, else eject locally.
  function automatic logic [ROUTE_W-1:0] xy_route(
    input logic [COORD_MAX_W-1:0] dx,
    input logic [COORD_MAX_W-1:0] dy,
    input logic [COORD_MAX_W-1:0] lx,
    input logic [COORD_MAX_W-1:0] ly
  );
    logic [ROUTE_W-1:0] r;
    r = '0;
    if (dx > lx)      r[PORT_EAST]  = 1'b1;
    else if (dx < lx) r[PORT_WEST]  = 1'b1;
    else if (dy > ly) r[PORT_NORTH] = 1'b1;
    else if (dy < ly) r[PORT_SOUTH] = 1'b1;
    else              r[PORT_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous flit FIFO with registered ready; head entry readable with no fall-through.
module noc_sync_fifo #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [FLIT_WIDTH-1:0] i_wdata,
  output logic [FLIT_WIDTH-1:0] o_rdata_c,
  output logic                  o_empty_c,
  output logic                  o_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [PW-1:0]         w_rd_ptr_nxt;
  logic                  r_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full_nxt;
  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];

  assign o_empty_c    = (r_wr_ptr == r_rd_ptr);
  assign o_ready      = r_ready;
  assign w_push       = i_push & r_ready;
  assign w_pop        = i_pop & ~o_empty_c;
  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  // Full when wrap bits differ and index bits match.
  assign w_full_nxt   = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
  assign o_rdata_c    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer and ready registers; ready reflects next-cycle fullness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_ready  <= ~w_full_nxt;
    end
  end

  // Storage write; data array needs no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/noc_input_route_buffer.sv
// Router input stage: buffers flits, XY-routes each packet at its head flit,
// and holds that route for every following flit up to the tail.
module noc_input_route_buffer
  import noc_input_route_buffer_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = noc_input_route_buffer_pkg::FLIT_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned COORD_W    = noc_input_route_buffer_pkg::COORD_W,
  parameter int unsigned LOCAL_X    = 0,
  parameter int unsigned LOCAL_Y    = 0
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [ROUTE_W-1:0]    out_route,
  output logic                  err_orphan
);

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic [FLIT_WIDTH-1:0] w_head;
  flit_type_e            w_ftype;
  logic [ROUTE_W-1:0]    w_calc_route;
  route_state_e          r_state;
  route_state_e          w_state_nxt;
  logic [ROUTE_W-1:0]    r_route;
  logic [ROUTE_W-1:0]    w_route_nxt;

  assign w_push   = in_valid & in_ready;
  assign out_flit = w_head;
  assign w_ftype  = flit_type_e'(w_head[FLIT_WIDTH-1 -: 2]);
  assign w_calc_route = xy_route(COORD_MAX_W'(w_head[COORD_W-1:0]),
                                 COORD_MAX_W'(w_head[2*COORD_W-1 -: COORD_W]),
                                 COORD_MAX_W'(LOCAL_X),
                                 COORD_MAX_W'(LOCAL_Y));

  noc_sync_fifo #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (noc_clk),
    .rst_n     (noc_rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (in_flit),
    .o_rdata_c (w_head),
    .o_empty_c (w_empty),
    .o_ready   (in_ready)
  );

  // Route FSM state and latched packet route.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state <= ST_IDLE;
      r_route <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_route <= w_route_nxt;
    end
  end

  // Next state, pop decision and allocator-facing outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_route_nxt = r_route;
    w_pop       = 1'b0;
    out_valid   = 1'b0;
    out_route   = '0;
    err_orphan  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if ((w_ftype == FT_HEAD) || (w_ftype == FT_SINGLE)) begin
            out_valid = 1'b1;
            out_route = w_calc_route;
            w_pop     = out_ready;
            if (out_ready && (w_ftype == FT_HEAD)) begin
              w_state_nxt = ST_ACTIVE;
              w_route_nxt = w_calc_route;
            end
          end else begin
            // Body/tail without a head: drop it and flag the error.
            err_orphan = 1'b1;
            w_pop      = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!w_empty) begin
          out_valid = 1'b1;
          out_route = r_route;
          w_pop     = out_ready;
          if (out_ready && (w_ftype == FT_TAIL)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_noc_input_route_buffer.sv
// Self-checking bench: queue-based packet model plus directed literal checks.
module tb_noc_input_route_buffer;

  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int LX    = 5;
  localparam int LY    = 6;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_flit;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_flit;
  logic [4:0]    out_route;
  logic          err_orphan;

  int checks   = 0;
  int failures = 0;

  noc_input_route_buffer #(
    .FLIT_WIDTH (FW),
    .DEPTH      (DEPTH),
    .COORD_W    (4),
    .LOCAL_X    (LX),
    .LOCAL_Y    (LY)
  ) dut (
    .noc_clk    (clk),
    .noc_rst_n  (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flit    (in_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_flit   (out_flit),
    .out_route  (out_route),
    .err_orphan (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int dx, input int dy, input int pay);
    return {t, 22'(pay), 4'(dy), 4'(dx)};
  endfunction

  // XY rule on plain integers; result is one-hot {LOCAL,NORTH,SOUTH,WEST,EAST}.
  function automatic logic [4:0] model_route(input logic [FW-1:0] f);
    int dx;
    int dy;
    dx = int'(f[3:0]);
    dy = int'(f[7:4]);
    if (dx > LX) return 5'b00001;
    if (dx < LX) return 5'b00010;
    if (dy > LY) return 5'b01000;
    if (dy < LY) return 5'b00100;
    return 5'b10000;
  endfunction

  // Behavioural model: queue of buffered flits, in-packet flag, latched route.
  logic [FW-1:0] mq[$];
  bit            m_active;
  logic [4:0]    m_route;
  bit            m_ready;
  bit            m_push;
  bit            m_pop;
  logic [FW-1:0] m_h;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_route  = '0;
      m_ready  = 1'b0;
    end else begin
      m_push = in_valid && m_ready;
      m_pop  = 1'b0;
      if (mq.size() > 0) begin
        m_h = mq[0];
        if (!m_active && (m_h[31:30] == T_BODY || m_h[31:30] == T_TAIL)) m_pop = 1'b1;
        else if (out_ready) m_pop = 1'b1;
        if (m_pop) begin
          if (!m_active && m_h[31:30] == T_HEAD) begin
            m_active = 1'b1;
            m_route  = model_route(m_h);
          end else if (m_active && m_h[31:30] == T_TAIL) begin
            m_active = 1'b0;
          end
          void'(mq.pop_front());
        end
      end
      if (m_push) mq.push_back(in_flit);
      m_ready = (mq.size() < DEPTH);
    end
  end

  // Compare process on the falling edge, away from the active edge.
  logic          e_valid;
  logic [4:0]    e_route;
  logic          e_orphan;
  logic [FW-1:0] e_flit;

  always @(negedge clk) begin
    e_valid  = 1'b0;
    e_route  = '0;
    e_orphan = 1'b0;
    e_flit   = '0;
    if (mq.size() > 0) begin
      e_flit = mq[0];
      if (m_active) begin
        e_valid = 1'b1;
        e_route = m_route;
      end else if (e_flit[31:30] == T_HEAD || e_flit[31:30] == T_SINGLE) begin
        e_valid = 1'b1;
        e_route = model_route(e_flit);
      end else begin
        e_orphan = 1'b1;
      end
    end
    chk("m_in_ready", 32'(in_ready), 32'(m_ready));
    chk("m_out_valid", 32'(out_valid), 32'(e_valid));
    chk("m_out_route", 32'(out_route), 32'(e_route));
    chk("m_err_orphan", 32'(err_orphan), 32'(e_orphan));
    if (e_valid) chk("m_out_flit", out_flit, e_flit);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int c);
    case ($urandom_range(0, 3))
      0:       return c - 1;
      1:       return c;
      2:       return c + 1;
      default: return int'($urandom_range(0, 15));
    endcase
  endfunction

  int  pushes;
  int  pops;
  bit  xfer;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_flit   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    cyc();
    chk("rel_in_ready", 32'(in_ready), 1);

    // SINGLE heading east
    in_flit = mk(T_SINGLE, LX + 2, LY, 11);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 1);
    chk("single_route", 32'(out_route), 32'h01);
    cyc();
    chk("single_popped", 32'(out_valid), 0);

    // HEAD, 2 BODY, TAIL heading south
    for (int i = 0; i < 4; i++) begin
      in_flit = mk((i == 0) ? T_HEAD : (i == 3) ? T_TAIL : T_BODY, LX, LY - 1, 100 + i);
      in_valid = 1'b1;
      cyc();
      chk("pkt_valid", 32'(out_valid), 1);
      chk("pkt_route", 32'(out_route), 32'h04);
      chk("pkt_flit_pay", 32'(out_flit[29:8]), 32'(100 + i));
    end
    in_valid = 1'b0;
    cyc();
    chk("pkt_done", 32'(out_valid), 0);

    // Fill to DEPTH with the allocator stalled
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_flit = mk((i == 0) ? T_HEAD : T_BODY, LX, LY + 3, 200 + i);
      in_valid = 1'b1;
      cyc();
    end
    chk("full_in_ready", 32'(in_ready), 0);
    in_flit = mk(T_BODY, LX, LY + 3, 200 + DEPTH);
    cyc();
    chk("full_hold", 32'(in_ready), 0);
    chk("full_route", 32'(out_route), 32'h08);
    out_ready = 1'b1;
    cyc();
    chk("pop_in_ready", 32'(in_ready), 1);

    // Sustained throughput with both sides active
    pushes = 0;
    pops   = 0;
    for (int k = 0; k < 8; k++) begin
      if (in_valid && in_ready) pushes++;
      if (out_valid && out_ready) pops++;
      xfer = in_valid && in_ready;
      cyc();
      if (xfer) in_flit = mk(T_BODY, 0, 0, 300 + k);
    end
    chk("tput_pushes", 32'(pushes), 8);
    chk("tput_pops", 32'(pops), 8);
    in_flit = mk(T_TAIL, 0, 0, 399);
    cyc();
    in_valid = 1'b0;
    repeat (6) cyc();
    chk("tput_drained", 32'(out_valid), 0);

    // Orphan BODY in IDLE, then a normal HEAD heading west
    in_flit = mk(T_BODY, 1, 1, 400);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("orphan_pulse", 32'(err_orphan), 1);
    chk("orphan_valid", 32'(out_valid), 0);
    cyc();
    chk("orphan_clear", 32'(err_orphan), 0);
    in_flit = mk(T_HEAD, LX - 2, LY, 401);
    in_valid = 1'b1;
    cyc();
    chk("after_orphan_route", 32'(out_route), 32'h02);
    in_flit = mk(T_TAIL, 0, 0, 402);
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();

    // Asynchronous reset mid-packet
    out_ready = 1'b0;
    in_flit = mk(T_HEAD, LX + 2, LY - 4, 500);
    in_valid = 1'b1;
    cyc();
    in_flit = mk(T_BODY, 0, 0, 501);
    cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_route", 32'(out_route), 0);
    chk("arst_ready", 32'(in_ready), 0);
    chk("arst_orphan", 32'(err_orphan), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    in_flit = mk(T_HEAD, LX, LY, 502);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_route", 32'(out_route), 32'h10);
    out_ready = 1'b1;
    in_flit = mk(T_TAIL, 0, 0, 503);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();

    // Randomized traffic against the model
    xfer = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (!in_valid || xfer) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_flit  = mk(2'($urandom_range(0, 3)), pick(LX), pick(LY), int'($urandom_range(0, 4000000)));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      xfer = in_valid && in_ready;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    chk("final_empty", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
